menu_ctl: RTL and testbench

MENU_CTL -- requirements
Module: menu_ctl

---
 rtl/menu_ctl.sv | 150 +++++++++++++++
 tb/tb_menu_ctl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_ctl.sv
// Menu controller: debounced-edge navigation, select/confirm flash, game handoff.
// Colours update only on the frame-tick edge so the renderer never sees a mid-line change.
module menu_ctl #(
    parameter int          FLASH_FRAMES = 30,
    parameter logic [11:0] COLOR_BG     = 12'h000,
    parameter logic [11:0] COLOR_FG     = 12'hFFF,
    parameter logic [11:0] COLOR_HL     = 12'hF80
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_select,
    input  logic        btn_back,
    input  logic        game_over,
    output logic [11:0] color1,
    output logic [11:0] color2,
    output logic [1:0]  sel_idx,
    output logic [1:0]  game_mode,
    output logic        game_start,
    output logic        menu_active
);

    localparam int CW_RAW = $clog2(FLASH_FRAMES + 1);
    localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;
    localparam logic [CW-1:0] LAST = CW'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_MENU,
        S_CONFIRM,
        S_GAME
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_hist;
    logic [3:0]    w_btn;
    logic [3:0]    w_edge;
    logic          w_up;
    logic          w_down;
    logic          w_sel;
    logic          w_back;
    logic          r_vq;
    logic          w_tick;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_sel_nxt;
    logic [1:0]    w_mode_nxt;
    logic          w_start_nxt;
    logic [11:0]   w_c1_nxt;
    logic [11:0]   w_c2_nxt;

    assign w_btn  = {btn_back, btn_select, btn_down, btn_up};
    assign w_edge = r_sync2 & ~r_hist;
    assign w_up   = w_edge[0];
    assign w_down = w_edge[1];
    assign w_sel  = w_edge[2];
    assign w_back = w_edge[3];
    assign w_tick = vblnk_in & ~r_vq;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
            r_vq    <= 1'b0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_vq    <= vblnk_in;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) r_state <= S_MENU;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_MENU: begin
                if (w_sel) w_state_nxt = S_CONFIRM;
            end
            S_CONFIRM: begin
                // back wins over a coincident final tick
                if (w_back)                        w_state_nxt = S_MENU;
                else if (w_tick && (r_cnt == LAST)) w_state_nxt = S_GAME;
            end
            S_GAME: begin
                if (game_over || w_back) w_state_nxt = S_MENU;
            end
            default: w_state_nxt = S_MENU;
        endcase
    end

    always_comb begin
        w_sel_nxt   = sel_idx;
        w_mode_nxt  = game_mode;
        w_cnt_nxt   = r_cnt;
        w_c1_nxt    = color1;
        w_c2_nxt    = color2;
        w_start_nxt = (r_state == S_CONFIRM) && (w_state_nxt == S_GAME);
        unique case (r_state)
            S_MENU: begin
                if (w_sel) begin
                    w_mode_nxt = sel_idx;
                    w_cnt_nxt  = '0;
                end else if (w_up && !w_down && (sel_idx != 2'd0)) begin
                    w_sel_nxt = sel_idx - 2'd1;
                end else if (w_down && !w_up && (sel_idx != 2'd3)) begin
                    w_sel_nxt = sel_idx + 2'd1;
                end
            end
            S_CONFIRM: begin
                if (!w_back && w_tick) w_cnt_nxt = r_cnt + CW'(1);
            end
            default: ;
        endcase
        if (w_tick) begin
            w_c1_nxt = COLOR_BG;
            w_c2_nxt = ((r_state == S_CONFIRM) && r_cnt[2]) ? COLOR_HL : COLOR_FG;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sel_idx     <= 2'd0;
            game_mode   <= 2'd0;
            game_start  <= 1'b0;
            menu_active <= 1'b1;
            color1      <= COLOR_BG;
            color2      <= COLOR_FG;
            r_cnt       <= '0;
        end else begin
            sel_idx     <= w_sel_nxt;
            game_mode   <= w_mode_nxt;
            game_start  <= w_start_nxt;
            menu_active <= (w_state_nxt != S_GAME);
            color1      <= w_c1_nxt;
            color2      <= w_c2_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_menu_ctl.sv
// Bench for menu_ctl: directed scenarios plus random stimulus
// against an event-level reference model of the menu behaviour.
module tb_menu_ctl;

    localparam int          FF = 30;
    localparam logic [11:0] BG = 12'h000;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] HL = 12'hF80;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_select = 1'b0;
    logic        btn_back = 1'b0;
    logic        game_over = 1'b0;
    logic [11:0] color1;
    logic [11:0] color2;
    logic [1:0]  sel_idx;
    logic [1:0]  game_mode;
    logic        game_start;
    logic        menu_active;

    int n_chk = 0;
    int n_fail = 0;

    // reference model
    int          m_sel, m_mode, m_frames;
    bit          m_flash, m_game, m_start, m_vprev, m_tick, m_pre_flash;
    logic [11:0] m_c1, m_c2;
    bit [3:0]    bq [3];
    int          dut_starts = 0;
    bit          vb_auto = 1'b0;
    int          vb_phase = 0;

    menu_ctl #(.FLASH_FRAMES(FF), .COLOR_BG(BG), .COLOR_FG(FG), .COLOR_HL(HL)) dut (
        .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_select(btn_select), .btn_back(btn_back),
        .game_over(game_over),
        .color1(color1), .color2(color2),
        .sel_idx(sel_idx), .game_mode(game_mode),
        .game_start(game_start), .menu_active(menu_active)
    );

    always #5 pclk = ~pclk;

    function automatic void model_reset();
        m_sel = 0; m_mode = 0; m_frames = 0;
        m_flash = 0; m_game = 0; m_start = 0;
        m_vprev = 0; m_tick = 0;
        m_c1 = BG; m_c2 = FG;
        for (int i = 0; i < 3; i++) bq[i] = '0;
    endfunction

    task automatic cyc();
        bit [3:0] b;
        bit [3:0] act;
        bit       tk;
        @(posedge pclk);
        b = {btn_back, btn_select, btn_down, btn_up};
        m_pre_flash = m_flash;
        if (rst) begin
            model_reset();
        end else begin
            // a press becomes an action two samples after it is first seen
            act = bq[1] & ~bq[2];
            bq[2] = bq[1]; bq[1] = bq[0]; bq[0] = b;
            tk = vblnk_in && !m_vprev;
            m_vprev = vblnk_in;
            m_tick = tk;
            m_start = 0;
            if (tk) begin
                m_c1 = BG;
                m_c2 = (m_flash && ((m_frames / 4) % 2 == 1)) ? HL : FG;
            end
            if (m_game) begin
                if (game_over || act[3]) m_game = 0;
            end else if (m_flash) begin
                if (act[3]) m_flash = 0;
                else if (tk) begin
                    m_frames++;
                    if (m_frames == FF) begin
                        m_flash = 0; m_game = 1; m_start = 1;
                    end
                end
            end else begin
                if (act[2]) begin
                    m_mode = m_sel; m_frames = 0; m_flash = 1;
                end else if (act[0] && !act[1]) begin
                    m_sel = (m_sel > 0) ? m_sel - 1 : 0;
                end else if (act[1] && !act[0]) begin
                    m_sel = (m_sel < 3) ? m_sel + 1 : 3;
                end
            end
        end
        #1;
        if (game_start === 1'b1) dut_starts++;
        if (vb_auto) begin
            vb_phase++;
            vblnk_in = ((vb_phase % 20) >= 16);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_select = v;
            default: btn_back = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (4) cyc();
        set_btn(b, 1'b0);
        repeat (5) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_chk++; if (sel_idx !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel_idx); end
        n_chk++; if (game_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", game_mode); end
        n_chk++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", game_start); end
        n_chk++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL reset_active got %b want 1", menu_active); end
        n_chk++; if (color1 !== BG) begin n_fail++; $display("FAIL reset_c1 got %h want %h", color1, BG); end
        n_chk++; if (color2 !== FG) begin n_fail++; $display("FAIL reset_c2 got %h want %h", color2, FG); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_nav();
        int exp_dn [4] = '{1, 2, 3, 3};
        int exp_up [4] = '{2, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            press(1);
            n_chk++;
            if (sel_idx !== 2'(exp_dn[i])) begin
                n_fail++; $display("FAIL nav_down%0d got %0d want %0d", i, sel_idx, exp_dn[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            press(0);
            n_chk++;
            if (sel_idx !== 2'(exp_up[i])) begin
                n_fail++; $display("FAIL nav_up%0d got %0d want %0d", i, sel_idx, exp_up[i]);
            end
        end
    endtask

    task automatic test_updown_same();
        press(1);
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL ud_pre got %0d want 1", sel_idx); end
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (4) cyc();
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (5) cyc();
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL ud_same got %0d want 1", sel_idx); end
        btn_select = 1'b1; btn_down = 1'b1;
        repeat (4) cyc();
        btn_select = 1'b0; btn_down = 1'b0;
        repeat (5) cyc();
        n_chk++; if (game_mode !== 2'd1) begin n_fail++; $display("FAIL seldn_mode got %0d want 1", game_mode); end
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL seldn_sel got %0d want 1", sel_idx); end
        n_chk++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL seldn_active got %b want 1", menu_active); end
        press(1);
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL confirm_ignore got %0d want 1", sel_idx); end
    endtask

    task automatic test_back_confirm();
        int k = 0;
        int s0;
        int c;
        vb_phase = 0;
        vb_auto = 1'b1;
        s0 = dut_starts;
        for (c = 0; c < 1000 && k < 10; c++) begin
            cyc();
            if (m_tick && m_pre_flash) k++;
        end
        n_chk++; if (k != 10) begin n_fail++; $display("FAIL back_ticks got %0d want 10", k); end
        press(3);
        n_chk++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL back_active got %b want 1", menu_active); end
        n_chk++; if (game_mode !== 2'd1) begin n_fail++; $display("FAIL back_mode got %0d want 1", game_mode); end
        n_chk++; if (dut_starts != s0) begin n_fail++; $display("FAIL back_nostart got %0d want %0d", dut_starts, s0); end
        c = 0;
        do begin cyc(); c++; end while (!m_tick && c < 100);
        n_chk++; if (color2 !== FG) begin n_fail++; $display("FAIL back_c2 got %h want %h", color2, FG); end
        press(1);
        n_chk++; if (sel_idx !== 2'd2) begin n_fail++; $display("FAIL back_nav got %0d want 2", sel_idx); end
    endtask

    task automatic test_flash();
        int k = 0;
        int s0;
        logic [11:0] prev;
        logic [11:0] expc;
        s0 = dut_starts;
        prev = color2;
        btn_select = 1'b1;
        for (int c = 0; c < 3000 && k < FF; c++) begin
            if (c == 4) btn_select = 1'b0;
            cyc();
            if (m_tick && m_pre_flash) begin
                k++;
                expc = (((k - 1) / 4) % 2 == 1) ? HL : FG;
                n_chk++;
                if (color2 !== expc) begin
                    n_fail++; $display("FAIL flash_c2 tick%0d got %h want %h", k, color2, expc);
                end
                n_chk++;
                if (game_start !== (k == FF)) begin
                    n_fail++; $display("FAIL flash_start tick%0d got %b want %b", k, game_start, k == FF);
                end
            end else if (!m_tick) begin
                n_chk++;
                if (color2 !== prev) begin
                    n_fail++; $display("FAIL flash_hold got %h want %h", color2, prev);
                end
                n_chk++;
                if (game_start !== 1'b0) begin
                    n_fail++; $display("FAIL flash_spurious got %b want 0", game_start);
                end
            end
            prev = color2;
        end
        btn_select = 1'b0;
        n_chk++; if (k != FF) begin n_fail++; $display("FAIL flash_timeout got %0d want %0d", k, FF); end
        n_chk++; if (game_mode !== 2'd2) begin n_fail++; $display("FAIL flash_mode got %0d want 2", game_mode); end
        n_chk++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL flash_active got %b want 0", menu_active); end
        repeat (3) cyc();
        n_chk++; if (dut_starts != s0 + 1) begin n_fail++; $display("FAIL flash_pulses got %0d want %0d", dut_starts - s0, 1); end
    endtask

    task automatic test_game_over();
        game_over = 1'b1;
        cyc();
        game_over = 1'b0;
        cyc();
        n_chk++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL go_active got %b want 1", menu_active); end
        n_chk++; if (sel_idx !== 2'd2) begin n_fail++; $display("FAIL go_sel got %0d want 2", sel_idx); end
        btn_up = 1'b1;
        repeat (1000) cyc();
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL hold_sel got %0d want 1", sel_idx); end
        btn_up = 1'b0;
        repeat (5) cyc();
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL hold_rel got %0d want 1", sel_idx); end
    endtask

    task automatic test_reset_mid();
        int s0;
        int c;
        press(2);
        repeat (40) cyc();
        s0 = dut_starts;
        rst = 1'b1;
        cyc();
        n_chk++; if (sel_idx !== 2'd0) begin n_fail++; $display("FAIL rstc_sel got %0d want 0", sel_idx); end
        n_chk++; if (game_mode !== 2'd0) begin n_fail++; $display("FAIL rstc_mode got %0d want 0", game_mode); end
        n_chk++; if (color2 !== FG) begin n_fail++; $display("FAIL rstc_c2 got %h want %h", color2, FG); end
        rst = 1'b0;
        repeat (3) cyc();
        press(1);
        press(2);
        for (c = 0; c < 2000 && !m_game; c++) cyc();
        n_chk++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL rstg_enter got %b want 0", menu_active); end
        s0 = dut_starts;
        rst = 1'b1;
        cyc();
        n_chk++; if (sel_idx !== 2'd0) begin n_fail++; $display("FAIL rstg_sel got %0d want 0", sel_idx); end
        n_chk++; if (game_mode !== 2'd0) begin n_fail++; $display("FAIL rstg_mode got %0d want 0", game_mode); end
        n_chk++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL rstg_start got %b want 0", game_start); end
        n_chk++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL rstg_active got %b want 1", menu_active); end
        n_chk++; if (color1 !== BG) begin n_fail++; $display("FAIL rstg_c1 got %h want %h", color1, BG); end
        n_chk++; if (color2 !== FG) begin n_fail++; $display("FAIL rstg_c2 got %h want %h", color2, FG); end
        btn_down = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (8) cyc();
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL rst_held got %0d want 1", sel_idx); end
        repeat (20) cyc();
        n_chk++; if (sel_idx !== 2'd1) begin n_fail++; $display("FAIL rst_held_once got %0d want 1", sel_idx); end
        n_chk++; if (dut_starts != s0) begin n_fail++; $display("FAIL rst_nostart got %0d want %0d", dut_starts, s0); end
        btn_down = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0)  btn_up = ~btn_up;
            if ($urandom_range(0, 7) == 0)  btn_down = ~btn_down;
            if ($urandom_range(0, 9) == 0)  btn_select = ~btn_select;
            if ($urandom_range(0, 59) == 0) btn_back = ~btn_back;
            game_over = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 799) == 0);
            cyc();
            n_chk++; if (sel_idx !== 2'(m_sel)) begin n_fail++; $display("FAIL rnd_sel c%0d got %0d want %0d", c, sel_idx, m_sel); end
            n_chk++; if (game_mode !== 2'(m_mode)) begin n_fail++; $display("FAIL rnd_mode c%0d got %0d want %0d", c, game_mode, m_mode); end
            n_chk++; if (game_start !== m_start) begin n_fail++; $display("FAIL rnd_start c%0d got %b want %b", c, game_start, m_start); end
            n_chk++; if (menu_active !== !m_game) begin n_fail++; $display("FAIL rnd_active c%0d got %b want %b", c, menu_active, !m_game); end
            n_chk++; if (color1 !== m_c1) begin n_fail++; $display("FAIL rnd_c1 c%0d got %h want %h", c, color1, m_c1); end
            n_chk++; if (color2 !== m_c2) begin n_fail++; $display("FAIL rnd_c2 c%0d got %h want %h", c, color2, m_c2); end
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0; btn_back = 1'b0;
        game_over = 1'b0; rst = 1'b0;
        repeat (5) cyc();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nav();
        test_updown_same();
        test_back_confirm();
        test_flash();
        test_game_over();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
